// File: rtl/vtg_param_gen.sv
// vtg_param_gen: parametrised video timing generator with shadowed runtime config,
// load-time validation and DLY extra output stages. Define VTG_EXT_SYNC_EN to add I_ext_sof.
module vtg_param_gen #(
  parameter int CNT_W = 12,
  parameter int DLY   = 0
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic             I_en,
  input  logic             I_cfg_load,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  input  logic             I_hs_pol,
  input  logic             I_vs_pol,
`ifdef VTG_EXT_SYNC_EN
  input  logic             I_ext_sof,
`endif
  output logic             O_cfg_pend,
  output logic             O_cfg_err,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_sof,
  output logic             O_sol
);

  // Two guard bits so a three-term timing sum can never wrap inside a comparison.
  localparam int SW = CNT_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0] hTotal, hSync, hBporch, hRes;
    logic [CNT_W-1:0] vTotal, vSync, vBporch, vRes;
    logic             hsPol, vsPol;
  } cfg_t;

  typedef struct packed {
    logic             de, hs, vs, sof, sol;
    logic [CNT_W-1:0] x, y;
  } vid_t;

  cfg_t             r_act, r_pendCfg;
  logic             r_cfgPend, r_cfgErr;
  logic [CNT_W-1:0] r_hCnt, r_vCnt;
  vid_t             r_stage [DLY+1];

  cfg_t             w_cfgIn;
  logic             w_loadOk, w_extSof, w_apply;
  logic             w_hLast, w_vLast, w_frameEnd;
  logic [SW-1:0]    w_hsEnd, w_haEnd, w_vsEnd, w_vaEnd, w_hOff, w_vOff;
  logic             w_hAct, w_vAct, w_hsRaw, w_vsRaw;
  vid_t             w_vidNext, w_rstVid;

  function automatic logic axisOk(input logic [CNT_W-1:0] total, sync, bporch, res);
    logic [SW-1:0] sum;
    sum = SW'(sync) + SW'(bporch) + SW'(res);
    return (sync != '0) && (res != '0) && (sum <= SW'(total));
  endfunction

  assign w_cfgIn  = {I_h_total, I_h_sync, I_h_bporch, I_h_res,
                     I_v_total, I_v_sync, I_v_bporch, I_v_res, I_hs_pol, I_vs_pol};
  assign w_loadOk = axisOk(I_h_total, I_h_sync, I_h_bporch, I_h_res) &
                    axisOk(I_v_total, I_v_sync, I_v_bporch, I_v_res);

`ifdef VTG_EXT_SYNC_EN
  assign w_extSof = I_ext_sof & I_en;
`else
  assign w_extSof = 1'b0;
`endif

  assign w_hLast    = (SW'(r_hCnt) + SW'(1)) >= SW'(r_act.hTotal);
  assign w_vLast    = (SW'(r_vCnt) + SW'(1)) >= SW'(r_act.vTotal);
  assign w_frameEnd = w_hLast & w_vLast;
  // A disabled generator sits at 0,0 already, so pending config can go live at once.
  assign w_apply    = r_cfgPend & (~I_en | w_frameEnd | w_extSof);

  assign w_hsEnd = SW'(r_act.hSync) + SW'(r_act.hBporch);
  assign w_haEnd = w_hsEnd + SW'(r_act.hRes);
  assign w_vsEnd = SW'(r_act.vSync) + SW'(r_act.vBporch);
  assign w_vaEnd = w_vsEnd + SW'(r_act.vRes);
  assign w_hOff  = SW'(r_hCnt) - w_hsEnd;
  assign w_vOff  = SW'(r_vCnt) - w_vsEnd;
  assign w_hAct  = (SW'(r_hCnt) >= w_hsEnd) && (SW'(r_hCnt) < w_haEnd);
  assign w_vAct  = (SW'(r_vCnt) >= w_vsEnd) && (SW'(r_vCnt) < w_vaEnd);
  assign w_hsRaw = r_hCnt < r_act.hSync;
  assign w_vsRaw = r_vCnt < r_act.vSync;

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (~I_en | w_extSof) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_hLast) begin
      r_hCnt <= '0;
      r_vCnt <= w_vLast ? '0 : r_vCnt + CNT_W'(1);
    end else begin
      r_hCnt <= r_hCnt + CNT_W'(1);
    end
  end

  // A load in the same cycle as an apply lands after it, so it stays pending.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_act     <= w_cfgIn;
      r_pendCfg <= w_cfgIn;
      r_cfgPend <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act     <= r_pendCfg;
        r_cfgPend <= 1'b0;
      end
      if (I_cfg_load) begin
        if (w_loadOk) begin
          r_pendCfg <= w_cfgIn;
          r_cfgPend <= 1'b1;
          r_cfgErr  <= 1'b0;
        end else begin
          r_cfgErr  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_vidNext    = '0;
    w_vidNext.hs = ~r_act.hsPol;
    w_vidNext.vs = ~r_act.vsPol;
    if (I_en) begin
      w_vidNext.de = w_hAct & w_vAct;
      w_vidNext.hs = r_act.hsPol ? w_hsRaw : ~w_hsRaw;
      w_vidNext.vs = r_act.vsPol ? w_vsRaw : ~w_vsRaw;
      if (w_hAct & w_vAct) begin
        w_vidNext.x   = w_hOff[CNT_W-1:0];
        w_vidNext.y   = w_vOff[CNT_W-1:0];
        w_vidNext.sol = (w_hOff == '0);
        w_vidNext.sof = (w_hOff == '0) && (w_vOff == '0);
      end
    end
  end

  always_comb begin
    w_rstVid    = '0;
    w_rstVid.hs = ~I_hs_pol;
    w_rstVid.vs = ~I_vs_pol;
  end

  // Stage 0 is the mandatory output register; stages 1..DLY add alignment delay.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      for (int i = 0; i <= DLY; i++) r_stage[i] <= w_rstVid;
    end else begin
      r_stage[0] <= w_vidNext;
      for (int i = 1; i <= DLY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign O_cfg_pend = r_cfgPend;
  assign O_cfg_err  = r_cfgErr;
  assign O_de       = r_stage[DLY].de;
  assign O_hs       = r_stage[DLY].hs;
  assign O_vs       = r_stage[DLY].vs;
  assign O_x        = r_stage[DLY].x;
  assign O_y        = r_stage[DLY].y;
  assign O_sof      = r_stage[DLY].sof;
  assign O_sol      = r_stage[DLY].sol;

endmodule

// File: tb/tb_vtg_param_gen.sv
// tb_vtg_param_gen: drives a DLY=0 and a DLY=3 vtg_param_gen in parallel and checks both
// against a raster-position model; directed frame/latency checks then randomized traffic.
module tb_vtg_param_gen;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst, en, cfgLoad, extSof;
  logic [W-1:0] hTotal, hSync, hBporch, hRes, vTotal, vSync, vBporch, vRes;
  logic         hsPol, vsPol;

  logic         pend0, err0, de0, hs0, vs0, sof0, sol0;
  logic [W-1:0] x0, y0;
  logic         pend3, err3, de3, hs3, vs3, sof3, sol3;
  logic [W-1:0] x3, y3;

  always #5 clk = ~clk;

  vtg_param_gen #(.CNT_W(W), .DLY(0)) dut0 (
    .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_cfg_load(cfgLoad),
    .I_h_total(hTotal), .I_h_sync(hSync), .I_h_bporch(hBporch), .I_h_res(hRes),
    .I_v_total(vTotal), .I_v_sync(vSync), .I_v_bporch(vBporch), .I_v_res(vRes),
    .I_hs_pol(hsPol), .I_vs_pol(vsPol),
`ifdef VTG_EXT_SYNC_EN
    .I_ext_sof(extSof),
`endif
    .O_cfg_pend(pend0), .O_cfg_err(err0), .O_de(de0), .O_hs(hs0), .O_vs(vs0),
    .O_x(x0), .O_y(y0), .O_sof(sof0), .O_sol(sol0)
  );

  vtg_param_gen #(.CNT_W(W), .DLY(3)) dut3 (
    .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_cfg_load(cfgLoad),
    .I_h_total(hTotal), .I_h_sync(hSync), .I_h_bporch(hBporch), .I_h_res(hRes),
    .I_v_total(vTotal), .I_v_sync(vSync), .I_v_bporch(vBporch), .I_v_res(vRes),
    .I_hs_pol(hsPol), .I_vs_pol(vsPol),
`ifdef VTG_EXT_SYNC_EN
    .I_ext_sof(extSof),
`endif
    .O_cfg_pend(pend3), .O_cfg_err(err3), .O_de(de3), .O_hs(hs3), .O_vs(vs3),
    .O_x(x3), .O_y(y3), .O_sof(sof3), .O_sol(sol3)
  );

  typedef struct {
    int hTotal, hSync, hBporch, hRes, vTotal, vSync, vBporch, vRes;
    bit hsPol, vsPol;
  } mcfg_t;

  typedef struct packed {
    logic         de, hs, vs, sof, sol;
    logic [W-1:0] x, y;
  } mvid_t;

  // Model state: linear raster position instead of separate h/v counters.
  mcfg_t mAct, mPend;
  bit    mPendFlag, mErr;
  int    mPos;
  mvid_t mStage [4];

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  bit baseHsPol, baseVsPol;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycleNo, got, exp);
    end
  endtask

  function automatic mcfg_t inputCfg();
    mcfg_t c;
    c.hTotal = int'(hTotal); c.hSync = int'(hSync); c.hBporch = int'(hBporch); c.hRes = int'(hRes);
    c.vTotal = int'(vTotal); c.vSync = int'(vSync); c.vBporch = int'(vBporch); c.vRes = int'(vRes);
    c.hsPol  = hsPol;        c.vsPol = vsPol;
    return c;
  endfunction

  function automatic bit cfgValid(input mcfg_t c);
    return c.hSync >= 1 && c.hRes >= 1 && c.hSync + c.hBporch + c.hRes <= c.hTotal &&
           c.vSync >= 1 && c.vRes >= 1 && c.vSync + c.vBporch + c.vRes <= c.vTotal;
  endfunction

  function automatic mvid_t idleVid(input bit hp, input bit vp);
    mvid_t v;
    v    = '0;
    v.hs = !hp;
    v.vs = !vp;
    return v;
  endfunction

  function automatic mvid_t videoAt(input mcfg_t c, input int pos, input bit enabled);
    mvid_t v;
    int h, ln, hx, vy;
    v = idleVid(c.hsPol, c.vsPol);
    if (enabled) begin
      h  = pos % c.hTotal;
      ln = pos / c.hTotal;
      hx = h - (c.hSync + c.hBporch);
      vy = ln - (c.vSync + c.vBporch);
      v.hs = c.hsPol ? (h < c.hSync) : !(h < c.hSync);
      v.vs = c.vsPol ? (ln < c.vSync) : !(ln < c.vSync);
      v.de = hx >= 0 && hx < c.hRes && vy >= 0 && vy < c.vRes;
      if (v.de) begin
        v.x   = hx[W-1:0];
        v.y   = vy[W-1:0];
        v.sol = (hx == 0);
        v.sof = (hx == 0) && (vy == 0);
      end
    end
    return v;
  endfunction

  task automatic modelEdge();
    mcfg_t c;
    bit    ext, frameEnd, apply;
    int    nextPos;
    if (rst) begin
      c = inputCfg();
      mAct = c; mPend = c; mPendFlag = 0; mErr = 0; mPos = 0;
      for (int i = 0; i < 4; i++) mStage[i] = idleVid(c.hsPol, c.vsPol);
    end else begin
      for (int i = 3; i > 0; i--) mStage[i] = mStage[i-1];
      mStage[0] = videoAt(mAct, mPos, en);
      ext      = extSof && en;
      frameEnd = (mPos == mAct.hTotal * mAct.vTotal - 1);
      apply    = mPendFlag && (!en || frameEnd || ext);
      nextPos  = (!en || ext || frameEnd) ? 0 : mPos + 1;
      if (apply) begin
        mAct = mPend;
        mPendFlag = 0;
      end
      if (cfgLoad) begin
        c = inputCfg();
        if (cfgValid(c)) begin
          mPend = c; mPendFlag = 1; mErr = 0;
        end else begin
          mErr = 1;
        end
      end
      mPos = nextPos;
    end
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput("video_dly0", 64'({de0, hs0, vs0, sof0, sol0, x0, y0}), 64'(mStage[0]));
    checkOutput("video_dly3", 64'({de3, hs3, vs3, sof3, sol3, x3, y3}), 64'(mStage[3]));
    checkOutput("pend_dly0", 64'(pend0), 64'(mPendFlag));
    checkOutput("err_dly0",  64'(err0),  64'(mErr));
    checkOutput("pend_dly3", 64'(pend3), 64'(mPendFlag));
    checkOutput("err_dly3",  64'(err3),  64'(mErr));
  endtask

  task automatic setBase();
    hTotal = 12'd20; hSync = 12'd2; hBporch = 12'd3; hRes = 12'd10;
    vTotal = 12'd8;  vSync = 12'd1; vBporch = 12'd2; vRes = 12'd4;
    hsPol  = baseHsPol; vsPol = baseVsPol;
  endtask

  task automatic randAxis(output logic [W-1:0] tot, sync, bp, res);
    int s, b, r, t;
    s = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    r = $urandom_range(0, 10);
    t = s + b + r + $urandom_range(0, 5);
    if ($urandom_range(0, 7) == 0 && t >= 2) t -= 2;
    tot = t[W-1:0]; sync = s[W-1:0]; bp = b[W-1:0]; res = r[W-1:0];
  endtask

  int  cntDe, cntHs, cntVs, cntSof, cntSol, maxX, maxY;
  int  sofIdx0, sofIdx3, solA, solB, lineDe, startCyc;
  bit  found;

  initial begin
    baseHsPol = 1; baseVsPol = 1;
    setBase();
    rst = 1; en = 1; cfgLoad = 0; extSof = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_de",   64'(de0),   64'd0);
    checkOutput("rst_hs",   64'(hs0),   64'd0);
    checkOutput("rst_vs3",  64'(vs3),   64'd0);
    checkOutput("rst_xy",   64'({x0, y0}), 64'd0);
    checkOutput("rst_pend", 64'(pend0), 64'd0);

    // One full frame of the small mode, plus first-SOF latency on both delays.
    rst = 0;
    cntDe = 0; cntHs = 0; cntVs = 0; cntSof = 0; cntSol = 0; maxX = 0; maxY = 0;
    sofIdx0 = -1; sofIdx3 = -1;
    for (int k = 1; k <= 200; k++) begin
      applyStimulus();
      if (k <= 160) begin
        cntDe += de0; cntHs += hs0; cntVs += vs0; cntSof += sof0; cntSol += sol0;
        if (int'(x0) > maxX) maxX = int'(x0);
        if (int'(y0) > maxY) maxY = int'(y0);
      end
      if (sof0 && sofIdx0 < 0) sofIdx0 = k;
      if (sof3 && sofIdx3 < 0) sofIdx3 = k;
    end
    checkOutput("frame_de",   64'(cntDe),  64'd40);
    checkOutput("frame_hs",   64'(cntHs),  64'd16);
    checkOutput("frame_vs",   64'(cntVs),  64'd20);
    checkOutput("frame_sof",  64'(cntSof), 64'd1);
    checkOutput("frame_sol",  64'(cntSol), 64'd4);
    checkOutput("frame_maxx", 64'(maxX),   64'd9);
    checkOutput("frame_maxy", 64'(maxY),   64'd3);
    checkOutput("sof_lat0",   64'(sofIdx0), 64'd66);
    checkOutput("sof_lat3",   64'(sofIdx3), 64'd69);

    // Rejected load: sum 15 exceeds total 10.
    hTotal = 12'd10; hSync = 12'd2; hBporch = 12'd3; hRes = 12'd10;
    cfgLoad = 1;
    applyStimulus();
    cfgLoad = 0;
    setBase();
    checkOutput("bad_err",  64'(err0),  64'd1);
    checkOutput("bad_pend", 64'(pend0), 64'd0);
    for (int k = 0; k < 37; k++) applyStimulus();

    // Mid-frame valid load of 30-clock lines.
    hTotal = 12'd30; hSync = 12'd4; hBporch = 12'd4; hRes = 12'd16;
    cfgLoad = 1;
    applyStimulus();
    cfgLoad = 0;
    setBase();
    checkOutput("good_pend", 64'(pend0), 64'd1);
    checkOutput("good_err",  64'(err0),  64'd0);
    for (int k = 0; k < 400 && pend0; k++) applyStimulus();
    checkOutput("pend_clear", 64'(pend0), 64'd0);
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      applyStimulus();
      found = sol0;
    end
    solA = cycleNo; solB = -1; lineDe = 1;
    for (int k = 0; k < 300; k++) begin
      applyStimulus();
      if (sol0) begin
        solB = cycleNo;
        break;
      end
      lineDe += de0;
    end
    checkOutput("new_line_len", 64'(solB - solA), 64'd30);
    checkOutput("new_line_de",  64'(lineDe),      64'd16);

    // Reset asserted with the counters at h=7, v=5.
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      if (mPos == 5 * mAct.hTotal + 7) begin
        found = 1;
        break;
      end
      applyStimulus();
    end
    checkOutput("rst_align", 64'(found), 64'd1);
    rst = 1;
    applyStimulus();
    checkOutput("mid_rst_de3", 64'({de3, hs3, vs3, sof3, sol3}), 64'd0);
    checkOutput("mid_rst_de0", 64'({de0, hs0, vs0, sof0, sol0}), 64'd0);
    rst = 0;
    startCyc = cycleNo; sofIdx0 = -1;
    for (int k = 0; k < 100 && sofIdx0 < 0; k++) begin
      applyStimulus();
      if (sof0) sofIdx0 = cycleNo - startCyc;
    end
    checkOutput("rst_sof_lat", 64'(sofIdx0), 64'd66);

    // Randomized enables, loads, resets and external syncs.
    baseHsPol = 0; baseVsPol = 1;
    setBase();
    rst = 1;
    applyStimulus();
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      setBase();
      rst = 0; cfgLoad = 0; extSof = 0;
      en = ($urandom_range(0, 15) != 0);
      r = $urandom_range(0, 999);
      if (r < 30) begin
        cfgLoad = 1;
        randAxis(hTotal, hSync, hBporch, hRes);
        randAxis(vTotal, vSync, vBporch, vRes);
        hsPol = 1'($urandom_range(0, 1));
        vsPol = 1'($urandom_range(0, 1));
      end else if (r < 33) begin
        rst = 1;
      end
`ifdef VTG_EXT_SYNC_EN
      extSof = ($urandom_range(0, 99) == 0);
`endif
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
